// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller:
//   - md_state_e : multiply/divide tracker state (IDLE, BUSY)
//   - T_UNUSED   : Tuse/Tnew encoding meaning "operand not used"
//   - REG_ZERO   : hard-wired zero register number (never a real dependency)
//   - raw_hazard : read-after-write test of one source against one producer
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [1:0] T_UNUSED = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when the producer writes the source register and its result will
  // not be ready by the time the consumer needs it.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst,
    input logic [1:0] tnew
  );
    return (src == dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// ---------------------------------------------------------------------------
// md_busy_tracker
// Tracks occupancy of the iterative multiply/divide unit. A start pulse
// loads a 4-bit down-counter with the operation latency; the unit reports
// busy for exactly that many cycles afterwards.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset (aborts any operation)
//   i_start  : a mult/div is in E this cycle
//   i_div    : 1 = divide, 0 = multiply (qualifies i_start)
//   o_busy   : registered busy flag (state == BUSY)
// ---------------------------------------------------------------------------
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_e  r_state;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic [3:0] w_lat;

  assign w_lat  = i_div ? DIV_CNT : MULT_CNT;
  assign o_busy = r_busy;

  // State, counter and busy flag advance together so o_busy stays registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= BUSY;
            r_cnt   <= w_lat;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
          end
        end
        BUSY: begin
          if (i_start) begin
            // Start while busy: restart with the new latency.
            r_state <= BUSY;
            r_cnt   <= w_lat;
            r_busy  <= 1'b1;
          end else if (r_cnt <= 4'd1) begin
            // Count hits zero on this edge: LAT busy cycles have elapsed.
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= BUSY;
            r_cnt   <= r_cnt - 4'd1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall controller for a 5-stage pipeline. Detects RAW hazards of the D-stage
// instruction against E and M producers (Tuse/Tnew model) and, optionally,
// structural stalls on the multiply/divide unit. On a stall F and D hold and
// a bubble is inserted into E; E, M and W always advance.
// Configuration macro: PIPE_MD_UNIT_EN
//   defined   -> md_busy_tracker instantiated, MD stalls enabled
//   undefined -> md_busy = 0, no MD stalls, MD inputs ignored
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   D_rs, D_rt              : D-stage source register numbers
//   D_Tuse_rs, D_Tuse_rt    : cycles until operand needed (3 = unused)
//   E_dst/E_Tnew, M_dst/M_Tnew : producer destination and result readiness
//   E_md_start, E_md_div    : mult/div issued in E, and its kind
//   D_md_use                : D instruction needs the MD unit
//   F_en, D_en, E_clr       : PC enable, IF/ID enable, ID/EX bubble
//   M_en, W_en              : always 1
//   md_busy                 : MD unit occupied (registered)
//   stall_cycles            : wrapping count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_dst,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        D_md_use,
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        M_en,
  output logic        W_en,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic        w_stall_rs;
  logic        w_stall_rt;
  logic        w_stall_md;
  logic        w_stall;
  logic        w_md_busy;
  logic [31:0] r_stall_cycles;

  // Register zero never carries a dependency; an unused operand (Tuse=3)
  // can never be beaten by Tnew, the explicit test just makes that obvious.
  assign w_stall_rs = (D_rs != REG_ZERO) && (D_Tuse_rs != T_UNUSED) &&
                      (raw_hazard(D_rs, D_Tuse_rs, E_dst, E_Tnew) ||
                       raw_hazard(D_rs, D_Tuse_rs, M_dst, M_Tnew));

  assign w_stall_rt = (D_rt != REG_ZERO) && (D_Tuse_rt != T_UNUSED) &&
                      (raw_hazard(D_rt, D_Tuse_rt, E_dst, E_Tnew) ||
                       raw_hazard(D_rt, D_Tuse_rt, M_dst, M_Tnew));

`ifdef PIPE_MD_UNIT_EN
  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_tracker (
    .clk     (clk),
    .reset   (reset),
    .i_start (E_md_start),
    .i_div   (E_md_div),
    .o_busy  (w_md_busy)
  );

  // A start in E this cycle blocks the D instruction as well: the unit
  // becomes busy at the next edge.
  assign w_stall_md = D_md_use && (w_md_busy || E_md_start);
`else
  logic w_unused_md;

  assign w_unused_md = ^{E_md_start, E_md_div, D_md_use, 4'(MULT_LAT), 4'(DIV_LAT)};
  assign w_md_busy   = 1'b0;
  assign w_stall_md  = 1'b0;
`endif

  assign w_stall = w_stall_rs || w_stall_rt || w_stall_md;

  assign F_en         = !w_stall;
  assign D_en         = !w_stall;
  assign E_clr        = w_stall;
  assign M_en         = 1'b1;
  assign W_en         = 1'b1;
  assign md_busy      = w_md_busy;
  assign stall_cycles = r_stall_cycles;

  // Stall-cycle counter: one increment per stalled cycle, wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

endmodule
